// File: rtl/tetris_pkg.sv
// tetris_pkg: board geometry and board array type shared by the playfield blocks.
package tetris_pkg;

    localparam int GRID_W = 10;
    localparam int GRID_H = 18;

    typedef logic board_t [0:GRID_W-1][0:GRID_H-1];

endpackage

// File: rtl/row_full_detect.sv
// row_full_detect: flags every row whose cells are all occupied.
module row_full_detect
    import tetris_pkg::*;
#(
    parameter int GRID_W = tetris_pkg::GRID_W,
    parameter int GRID_H = tetris_pkg::GRID_H
) (
    input  logic              grid [0:GRID_W-1][0:GRID_H-1],
    output logic [GRID_H-1:0] row_full
);

    always_comb begin
        row_full = '1;
        for (int y = 0; y < GRID_H; y++)
            for (int x = 0; x < GRID_W; x++)
                if (!grid[x][y]) row_full[y] = 1'b0;
    end

endmodule

// File: rtl/delete_row.sv
// delete_row: removes all full rows in one pass and drops the survivors toward the bottom.
module delete_row
    import tetris_pkg::*;
#(
    parameter int GRID_W = tetris_pkg::GRID_W,
    parameter int GRID_H = tetris_pkg::GRID_H
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              grid     [0:GRID_W-1][0:GRID_H-1],
    output logic              new_grid [0:GRID_W-1][0:GRID_H-1],
    output logic [4:0]        rows_cleared,
    output logic [GRID_H-1:0] row_full
);

    logic [GRID_H-1:0] full;
    logic              nxt_grid [0:GRID_W-1][0:GRID_H-1];
    int                dest     [0:GRID_H-1];
    int                below;

    row_full_detect #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_detect (
        .grid     (grid),
        .row_full (full)
    );

    // A surviving row drops by the number of full rows beneath it; each output row
    // selects the unique source whose destination matches it, so no variable writes.
    always_comb begin
        below = 0;
        for (int y = GRID_H - 1; y >= 0; y--) begin
            dest[y] = y + below;
            below   = below + (full[y] ? 1 : 0);
        end
        nxt_grid = '{default: 1'b0};
        for (int o = 0; o < GRID_H; o++)
            for (int y = 0; y <= o; y++)
                if (!full[y] && dest[y] == o)
                    for (int x = 0; x < GRID_W; x++)
                        nxt_grid[x][o] = grid[x][y];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            new_grid     <= '{default: 1'b0};
            rows_cleared <= '0;
            row_full     <= '0;
        end else begin
            new_grid     <= nxt_grid;
            rows_cleared <= 5'(below);
            row_full     <= full;
        end
    end

endmodule

// File: tb/tb_delete_row.sv
// tb_delete_row: directed vectors with hand-computed boards for delete_row.
module tb_delete_row;
    import tetris_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    board_t      grid;
    board_t      new_grid;
    logic [4:0]  rows_cleared;
    logic [17:0] row_full;
    logic [9:0]  exp_rows [0:17];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 Clk = ~Clk;

    delete_row dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .grid         (grid),
        .new_grid     (new_grid),
        .rows_cleared (rows_cleared),
        .row_full     (row_full)
    );

    task automatic clear_grid();
        for (int y = 0; y < 18; y++)
            for (int x = 0; x < 10; x++)
                grid[x][y] = 1'b0;
    endtask

    // Row patterns are written left to right: bit 9 is x=0, bit 0 is x=9.
    task automatic set_row(input int y, input logic [9:0] p);
        for (int x = 0; x < 10; x++) grid[x][y] = p[9-x];
    endtask

    task automatic clear_exp();
        for (int y = 0; y < 18; y++) exp_rows[y] = '0;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step_check(input string tag, input logic [4:0] rc, input logic [17:0] rf);
        logic [255:0] o;
        logic [255:0] e;
        o = '0;
        e = '0;
        @(posedge Clk);
        #1;
        for (int y = 0; y < 18; y++)
            for (int x = 0; x < 10; x++) begin
                o[y*10+x] = new_grid[x][y];
                e[y*10+x] = exp_rows[y][9-x];
            end
        chk({tag, " new_grid"}, o, e);
        chk({tag, " rows_cleared"}, 256'(rows_cleared), 256'(rc));
        chk({tag, " row_full"}, 256'(row_full), 256'(rf));
    endtask

    initial begin
        Reset = 1'b1;
        clear_grid();
        for (int y = 0; y < 18; y++) set_row(y, 10'h3FF);
        clear_exp();
        step_check("reset", 5'd0, 18'h0);

        Reset = 1'b0;
        clear_grid();
        set_row(17, 10'b1111111110);
        clear_exp();
        exp_rows[17] = 10'b1111111110;
        step_check("no_full", 5'd0, 18'h0);

        set_row(17, 10'b1111111111);
        clear_exp();
        step_check("bottom_full", 5'd1, 18'h20000);

        clear_grid();
        set_row(17, 10'h3FF);
        set_row(16, 10'b1010101010);
        set_row(15, 10'h3FF);
        set_row(14, 10'b1000000000);
        clear_exp();
        exp_rows[17] = 10'b1010101010;
        exp_rows[16] = 10'b1000000000;
        step_check("split_two", 5'd2, 18'h28000);

        clear_grid();
        set_row(17, 10'h3FF);
        set_row(16, 10'b0000000001);
        set_row(12, 10'h3FF);
        set_row(10, 10'h3FF);
        set_row(5, 10'b1100000011);
        set_row(0, 10'b0000011111);
        clear_exp();
        exp_rows[17] = 10'b0000000001;
        exp_rows[8]  = 10'b1100000011;
        exp_rows[3]  = 10'b0000011111;
        step_check("three_gaps", 5'd3, 18'h21400);

        Reset = 1'b1;
        clear_grid();
        set_row(17, 10'h3FF);
        set_row(16, 10'b1010101010);
        set_row(15, 10'h3FF);
        set_row(14, 10'b1000000000);
        clear_exp();
        step_check("reset_override", 5'd0, 18'h0);

        Reset = 1'b0;
        exp_rows[17] = 10'b1010101010;
        exp_rows[16] = 10'b1000000000;
        step_check("after_reset", 5'd2, 18'h28000);

        for (int y = 0; y < 18; y++) set_row(y, 10'h3FF);
        clear_exp();
        step_check("all_full", 5'd18, 18'h3FFFF);

        clear_grid();
        set_row(0, 10'h3FF);
        set_row(17, 10'b1100110011);
        set_row(9, 10'b0111111111);
        clear_exp();
        exp_rows[17] = 10'b1100110011;
        exp_rows[9]  = 10'b0111111111;
        step_check("top_full", 5'd1, 18'h00001);

        clear_grid();
        set_row(17, 10'b0000000001);
        clear_exp();
        exp_rows[17] = 10'b0000000001;
        step_check("no_history", 5'd0, 18'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/delete_row.md
DELETE_ROW -- requirements
Module: delete_row

Interface
REQ-001 Parameter GRID_W, default 10, board width in columns (x index).
REQ-002 Parameter GRID_H, default 18, board height in rows (y index, 0 = top, GRID_H-1 = bottom).
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on rising Clk.
REQ-005 grid  input  unpacked [0:GRID_W-1][0:GRID_H-1] of 1 bit  current board, grid[x][y]=1 means cell occupied.
REQ-006 new_grid  output  unpacked [0:GRID_W-1][0:GRID_H-1] of 1 bit  registered board after full-row removal.
REQ-007 rows_cleared  output  5  registered count of full rows removed in the last evaluated grid (0..GRID_H).
REQ-008 row_full  output  GRID_H  registered per-row flag, bit y=1 when row y of the evaluated grid was full.

Function
REQ-009 Row y SHALL be full when grid[x][y]=1 for every x in 0..GRID_W-1; any 0 makes it not full.
REQ-010 Every full row SHALL be deleted; all non-full rows SHALL keep their relative top-to-bottom order and compact toward the bottom (y=GRID_H-1).
REQ-011 With k full rows removed, output rows 0..k-1 SHALL be all zero and rows k..GRID_H-1 SHALL hold the surviving rows in original order.
REQ-012 A non-full row at index y SHALL move to y+n, n = number of full rows with index > y; its column contents SHALL be unchanged.
REQ-013 Full-row detection and compaction SHALL be combinational from grid; new_grid, rows_cleared and row_full SHALL register it on each rising Clk (latency exactly 1 cycle, evaluated every cycle, no handshake).
REQ-014 No full rows: new_grid SHALL equal grid one cycle later, rows_cleared=0, row_full=0.
REQ-015 All rows full: new_grid SHALL be all zero, rows_cleared=GRID_H, row_full all ones.
REQ-016 Non-contiguous full rows SHALL be handled in the same cycle as contiguous ones; there is no limit of 4.
REQ-017 Output SHALL depend only on the grid sampled at that edge; no history is kept between cycles.
REQ-018 rows_cleared SHALL equal the population count of row_full.

Reset
REQ-019 When Reset=1 at a rising Clk, new_grid SHALL become all zero, rows_cleared=0, row_full=0, regardless of grid.
REQ-020 Reset SHALL override evaluation; the first edge with Reset=0 SHALL register the compaction of the then-current grid.

Structure
REQ-021 GRID_W, GRID_H and the board array type SHALL live in a shared package tetris_pkg used by this block and its neighbours.
REQ-022 One sub-module row_full_detect SHALL compute the GRID_H-bit full-row vector from grid; compaction and registers remain in delete_row.

Verification
REQ-023 Row 17 cols 0-8 =1, col 9 =0, rest 0 -> next edge new_grid==grid, rows_cleared=0, row_full=0.
REQ-024 Then set grid[9][17]=1 -> next edge new_grid row 17 = former row 16 (all 0), row 0 all 0, rows_cleared=1, row_full[17]=1.
REQ-025 Rows 17,15 full, row 16 = pattern 1010101010, row 14 = single cell at x=0 -> new_grid row 17 = 1010101010, row 16 = cell x=0, rows 0-15 zero, rows_cleared=2.
REQ-026 All 18 rows full -> new_grid all zero, rows_cleared=18, row_full=18'h3FFFF.
REQ-027 Reset=1 while grid has full rows -> outputs all zero at that edge; Reset=0 -> compacted result on next edge.
